counter60_display: RTL and testbench
====================================

Name: counter60_display

Overview:
- Downstream consumer of the mod-60 counter's 6-bit count value and carry pulse.
- Converts the binary value 0..59 to two BCD digits with an iterative subtract-by-10 FSM.
- Drives a time-multiplexed two-digit active-low 7-segment display; the decimal point toggles on each counter carry.
- Sits between the counter chain and the board's display pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit scan slot; legal range 2..2^20.
- MAX_VAL, 59: largest legal input value; values above it are flagged as errors.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- val_in  in  6  binary value from the counter.
- val_we  in  1  one-cycle strobe: sample val_in.
- carry_in  in  1  counter carry output; level, asynchronous to the display logic.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low; seg[0]=a.
- dp  out  1  decimal point, active-low.
- an  out  2  digit enables, active-low; an[0]=ones, an[1]=tens.
- busy  out  1  conversion in progress.
- val_err  out  1  sticky flag: a value above MAX_VAL was written.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and state return to their reset values, including mid-conversion; a pending write is discarded.
  - Output reset values: seg=7'h7F, dp=1, an=2'b11, busy=0, val_err=0.
  - Internal reset values: state=IDLE, tens=0, ones=0, scan counter=0, sel=0, dp toggle state=0, pending invalid.
- FSM states:
  - IDLE:
    - val_we=1 with val_in<=MAX_VAL: work<=val_in, tcnt<=0, go to CONV, busy<=1.
    - val_we=1 with val_in>MAX_VAL: set val_err, load the dash code into both digits, stay in IDLE.
  - CONV:
    - work>=10: work<=work-10, tcnt<=tcnt+1.
    - work<10: tens<=tcnt, ones<=work (commit).
    - After commit: if a pending write is valid, load it and stay in CONV; otherwise go to IDLE with busy<=0.
- Latency: for value v, digits commit at the edge floor(v/10)+1 after the sampling edge.
  - v=0: 1 edge. v=59: 6 edges.
- Write during busy: stored in a one-entry pending slot; last write wins, so a later write overwrites an earlier pending one.
- Write in the same cycle as commit: goes to the pending slot and is loaded after the commit.
- Pending value above MAX_VAL: sets val_err when loaded and shows dashes; no conversion is started.
- val_err is sticky; it clears only on reset.
- Arithmetic: work is 6 bits, tcnt is 3 bits; no value can underflow.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps; sel toggles on the wrap.
  - sel=0: an=2'b10, seg shows ones. sel=1: an=2'b01, seg shows tens.
  - seg, an and dp are registered and updated every cycle, so the first edge after reset shows an=2'b10 with seg=7'b1000000 (ones digit '0').
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Dash=3F, blank=7F.
- dp:
  - carry_in passes through a 2-flop synchronizer, then a rising-edge detect toggles the dp state.
  - dp output = ~dp_state on both digits.
  - Carry rising edge 2–3 cycles after the input rises; pulses shorter than 1 clk are not guaranteed to be seen.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when tens=0 and the display is not in error, the tens slot shows blank (7F).
- Undefined: the tens slot shows '0' (40).

Decomposition:
- Shared package counter60_pkg:
  - Segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - Digit-code typedef: 4-bit; code 4'hE means dash, 4'hF means blank.
  - Default MAX_VAL.
- One combinational sub-module, seg7_decode: 4-bit digit code to 7-bit active-low segments.
  - Instantiated once, fed by the sel mux.

Test Plan (SCAN_DIV=4 in bench):
- Reset: rst=0 mid-scan, then released → seg=7F, an=11, busy=0 while in reset; first edge after release gives an=10, seg=40.
- Conversion of 59: write 59 → busy high for 6 edges. Scan shows tens 5 (seg=12) and ones 9 (seg=10). an alternates every 4 cycles.
- Conversion of 0: write 0 → commit after 1 edge, ones=40.
  - Tens shows 7F with LEADING_ZERO_BLANK_EN defined.
  - Tens shows 40 with it undefined.
- Writes during busy: write 45, then write 12 and 37 while busy → final display 37 (tens 30, ones 78). 12 is never displayed.
- Out-of-range value: write 62 → val_err=1 and both digits show 3F. A following write of 7 shows 07 while val_err stays 1.
- Carry toggling: carry_in high for 3 cycles, twice → dp goes 1→0→1, each change 3 cycles after the rising input. Reset asserted mid-conversion of 50 → busy=0 immediately and digits return to 0.

Source files
------------

// File: rtl/counter60_pkg.sv
// Shared constants for the mod-60 display path: segment codes, digit codes,
// FSM state encoding and the default largest legal counter value.
package counter60_pkg;

   // 4-bit digit code: 0..9 decimal, 4'hE dash, 4'hF blank
   typedef logic [3:0] digit_t;

   localparam digit_t DIG_DASH  = 4'hE;
   localparam digit_t DIG_BLANK = 4'hF;

   // active-low segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int MAX_VAL_DEF = 59;

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low 7-segment pattern; unused codes show blank.
module seg7_decode
   import counter60_pkg::*;
(
   input  digit_t     code,
   output logic [6:0] seg
);

   // pure lookup, no state
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:     seg = SEG_0;
         4'd1:     seg = SEG_1;
         4'd2:     seg = SEG_2;
         4'd3:     seg = SEG_3;
         4'd4:     seg = SEG_4;
         4'd5:     seg = SEG_5;
         4'd6:     seg = SEG_6;
         4'd7:     seg = SEG_7;
         4'd8:     seg = SEG_8;
         4'd9:     seg = SEG_9;
         DIG_DASH: seg = SEG_DASH;
         default:  seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/counter60_display.sv
// Two-digit multiplexed 7-segment driver for the mod-60 counter.
// Binary value -> BCD by repeated subtract-by-10; one-entry pending slot
// absorbs writes arriving during a conversion (last write wins).
// Optional macro LEADING_ZERO_BLANK_EN: blank the tens digit when it is 0.
module counter60_display
   import counter60_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int MAX_VAL  = MAX_VAL_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] val_in,
   input  logic       val_we,
   input  logic       carry_in,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] an,
   output logic       busy,
   output logic       val_err
);

   localparam int         SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [5:0] MAX6  = 6'(MAX_VAL);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   state_t      state, state_nxt;
   logic [5:0]  work;
   logic [2:0]  tcnt;
   digit_t      tens, ones;
   logic        pend_vld;
   logic [5:0]  pend_val;

   logic        done, ld_req, ld_ok;
   logic [5:0]  ld_val;

   logic [SW-1:0] scan_cnt;
   logic          sel;
   logic [2:0]    carry_s;
   logic          dp_state, rise, dp_nxt;
   digit_t        tens_code, dig_sel;
   logic [6:0]    seg_dec;

   // conversion finishes when the remainder is a single digit; a new value is
   // taken either from a write in IDLE or, at commit, from this cycle's write
   // or the pending slot (a same-cycle write is the newest, so it wins)
   always_comb begin
      done   = (state == CONV) && (work < 6'd10);
      ld_req = 1'b0;
      ld_val = val_in;
      if (state == IDLE) begin
         ld_req = val_we;
      end else if (done) begin
         ld_req = val_we | pend_vld;
         ld_val = val_we ? val_in : pend_val;
      end
      ld_ok  = (ld_val <= MAX6);
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // next state: an out-of-range load never starts a conversion
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ld_req && ld_ok) state_nxt = CONV;
         CONV: if (done)            state_nxt = (ld_req && ld_ok) ? CONV : IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state == CONV);
   end

   // conversion datapath, pending slot and sticky error; a load on the commit
   // edge is applied after the commit so dashes override committed digits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         work     <= '0;
         tcnt     <= '0;
         tens     <= 4'd0;
         ones     <= 4'd0;
         pend_vld <= 1'b0;
         pend_val <= '0;
         val_err  <= 1'b0;
      end else begin
         if (state == CONV) begin
            if (!done) begin
               work <= work - 6'd10;
               tcnt <= tcnt + 3'd1;
               if (val_we) begin
                  pend_vld <= 1'b1;
                  pend_val <= val_in;
               end
            end else begin
               tens     <= {1'b0, tcnt};
               ones     <= work[3:0];
               pend_vld <= 1'b0;
            end
         end
         if (ld_req) begin
            if (ld_ok) begin
               work <= ld_val;
               tcnt <= '0;
            end else begin
               val_err <= 1'b1;
               tens    <= DIG_DASH;
               ones    <= DIG_DASH;
            end
         end
      end
   end

   // digit scan: sel flips each time the slot counter wraps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         sel      <= 1'b0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         sel      <= ~sel;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // carry synchronizer plus edge history; dp_state flips on each rising edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         carry_s  <= '0;
         dp_state <= 1'b0;
      end else begin
         carry_s  <= {carry_s[1:0], carry_in};
         dp_state <= dp_nxt;
      end
   end

   assign rise   = carry_s[1] & ~carry_s[2];
   assign dp_nxt = dp_state ^ rise;

`ifdef LEADING_ZERO_BLANK_EN
   assign tens_code = (tens == 4'd0) ? DIG_BLANK : tens;
`else
   assign tens_code = tens;
`endif

   assign dig_sel = sel ? tens_code : ones;

   seg7_decode u_dec (
      .code (dig_sel),
      .seg  (seg_dec)
   );

   // registered pin drivers; dp takes the post-toggle value so it moves on the
   // same edge as dp_state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg <= SEG_BLANK;
         an  <= 2'b11;
         dp  <= 1'b1;
      end else begin
         seg <= seg_dec;
         an  <= sel ? 2'b01 : 2'b10;
         dp  <= ~dp_nxt;
      end
   end

endmodule

// File: tb/tb_counter60_display.sv
// Bench for counter60_display with SCAN_DIV=4: directed vector table,
// multi-cycle corner sequences and a randomized run against a simple model.
module tb_counter60_display;

   localparam int SD  = 4;
   localparam int MAXV = 59;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] TENS0 = 7'h7F;
`else
   localparam logic [6:0] TENS0 = 7'h40;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] val_in = '0;
   logic       val_we = 1'b0;
   logic       carry_in = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] an;
   logic       busy;
   logic       val_err;

   int checks = 0;
   int errors = 0;

   counter60_display #(.SCAN_DIV(SD), .MAX_VAL(MAXV)) dut (
      .clk(clk), .rst(rst), .val_in(val_in), .val_we(val_we),
      .carry_in(carry_in), .seg(seg), .dp(dp), .an(an),
      .busy(busy), .val_err(val_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int         v;
      logic [6:0] t;
      logic [6:0] o;
      int         cyc;
      logic       err;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] exp_tens(input int v);
      if (v > MAXV) return 7'h3F;
      if (v / 10 == 0) return TENS0;
      return seg_of(v / 10);
   endfunction

   function automatic logic [6:0] exp_ones(input int v);
      if (v > MAXV) return 7'h3F;
      return seg_of(v % 10);
   endfunction

   // strobe one write, then count cycles with busy high (bounded)
   task automatic write_val(input logic [5:0] v, output int cyc);
      val_in = v;
      val_we = 1'b1;
      tick();
      val_we = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         tick();
      end
   endtask

   // watch the scan for three slots; report digits seen per slot and any
   // illegal an value or slot that is not SD cycles long
   task automatic observe(output logic [7:0] t_seen, output logic [7:0] o_seen, output int bad);
      logic [1:0] hist [3*SD];
      int last_tr;
      t_seen = 8'hFF;
      o_seen = 8'hFF;
      bad = 0;
      last_tr = -1;
      tick();
      for (int i = 0; i < 3*SD; i++) begin
         tick();
         hist[i] = an;
         if (an == 2'b10)      o_seen = {1'b0, seg};
         else if (an == 2'b01) t_seen = {1'b0, seg};
         else                  bad++;
         if (i > 0 && hist[i] != hist[i-1]) begin
            if (last_tr >= 0 && i - last_tr != SD) bad++;
            last_tr = i;
         end
      end
   endtask

   initial begin
      int cyc;
      int bad;
      int saw12;
      int v;
      logic [7:0] ts, os;
      logic m_err;

      tbl[0] = '{0,  TENS0, 7'h40, 1, 1'b0};
      tbl[1] = '{9,  TENS0, 7'h10, 1, 1'b0};
      tbl[2] = '{10, 7'h79, 7'h40, 2, 1'b0};
      tbl[3] = '{59, 7'h12, 7'h10, 6, 1'b0};
      tbl[4] = '{45, 7'h19, 7'h12, 5, 1'b0};
      tbl[5] = '{62, 7'h3F, 7'h3F, 0, 1'b1};
      tbl[6] = '{7,  TENS0, 7'h78, 1, 1'b1};
      tbl[7] = '{33, 7'h30, 7'h30, 4, 1'b1};
      tbl[8] = '{60, 7'h3F, 7'h3F, 0, 1'b1};

      // reset state
      repeat (3) tick();
      chk("rst_seg", seg, 7'h7F);
      chk("rst_an", an, 2'b11);
      chk("rst_busy", busy, 1'b0);
      chk("rst_dp", dp, 1'b1);
      chk("rst_err", val_err, 1'b0);
      rst = 1'b1;
      tick();
      chk("first_an", an, 2'b10);
      chk("first_seg", seg, 7'h40);

      // reset asserted mid-scan
      repeat (2) tick();
      #2 rst = 1'b0;
      #1;
      chk("midscan_rst_seg", seg, 7'h7F);
      chk("midscan_rst_an", an, 2'b11);
      tick();
      rst = 1'b1;
      tick();
      chk("rel_an", an, 2'b10);
      chk("rel_seg", seg, 7'h40);

      // directed vectors
      for (int i = 0; i < 9; i++) begin
         write_val(6'(tbl[i].v), cyc);
         chk($sformatf("busy_cyc_v%0d", tbl[i].v), cyc, tbl[i].cyc);
         chk($sformatf("err_v%0d", tbl[i].v), val_err, tbl[i].err);
         observe(ts, os, bad);
         chk($sformatf("tens_v%0d", tbl[i].v), ts, {1'b0, tbl[i].t});
         chk($sformatf("ones_v%0d", tbl[i].v), os, {1'b0, tbl[i].o});
         chk($sformatf("scan_v%0d", tbl[i].v), bad, 0);
      end

      // writes during busy: 45, then 12 and 37 while converting; 12 is dropped
      saw12 = 0;
      val_in = 6'd45; val_we = 1'b1; tick();
      val_in = 6'd12; tick();
      val_we = 1'b0;  tick();
      val_in = 6'd37; val_we = 1'b1; tick();
      val_we = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         if (seg == 7'h24 || (an == 2'b01 && seg == 7'h79)) saw12++;
         cyc++;
         tick();
      end
      chk("pend_busy_bounded", (cyc < 100), 1'b1);
      observe(ts, os, bad);
      chk("pend_saw12", saw12, 0);
      chk("pend_tens", ts, 8'h30);
      chk("pend_ones", os, 8'h78);

      // write landing on the commit edge of a conversion of 0
      val_in = 6'd0; val_we = 1'b1; tick();
      val_in = 6'd26; tick();
      val_we = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         tick();
      end
      chk("commit_wr_busy", cyc, 3);
      observe(ts, os, bad);
      chk("commit_wr_tens", ts, 8'h24);
      chk("commit_wr_ones", os, 8'h02);

      // carry toggles dp three edges after the input rises
      chk("dp_init", dp, 1'b1);
      carry_in = 1'b1;
      tick(); chk("dp1_e1", dp, 1'b1);
      tick(); chk("dp1_e2", dp, 1'b1);
      tick(); chk("dp1_e3", dp, 1'b0);
      carry_in = 1'b0;
      repeat (4) tick();
      chk("dp1_hold", dp, 1'b0);
      carry_in = 1'b1;
      tick();
      tick(); chk("dp2_e2", dp, 1'b0);
      tick(); chk("dp2_e3", dp, 1'b1);
      carry_in = 1'b0;
      repeat (4) tick();
      chk("dp2_hold", dp, 1'b1);

      // reset in the middle of converting 50
      val_in = 6'd50; val_we = 1'b1; tick();
      val_we = 1'b0;
      tick(); tick();
      chk("conv50_busy", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("conv50_rst_busy", busy, 1'b0);
      chk("conv50_rst_seg", seg, 7'h7F);
      chk("conv50_rst_an", an, 2'b11);
      chk("conv50_rst_err", val_err, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("conv50_rel_seg", seg, 7'h40);
      observe(ts, os, bad);
      chk("conv50_tens", ts, {1'b0, TENS0});
      chk("conv50_ones", os, 8'h40);
      chk("conv50_busy_after", busy, 1'b0);

      // randomized values against the arithmetic model
      m_err = 1'b0;
      for (int i = 0; i < 25; i++) begin
         v = int'($urandom_range(0, 63));
         if (v > MAXV) m_err = 1'b1;
         write_val(6'(v), cyc);
         chk($sformatf("rnd_cyc_v%0d", v), cyc, (v > MAXV) ? 0 : v / 10 + 1);
         chk($sformatf("rnd_err_v%0d", v), val_err, m_err);
         observe(ts, os, bad);
         chk($sformatf("rnd_tens_v%0d", v), ts, {1'b0, exp_tens(v)});
         chk($sformatf("rnd_ones_v%0d", v), os, {1'b0, exp_ones(v)});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
